// File: rtl/sort_pkg.sv
// Shared constants, FSM state type and median-index helper for the sort statistics collector.
package sort_pkg;
   localparam int DATA_W    = 8;
   localparam int N_DEFAULT = 10;

   typedef enum logic {IDLE, COLLECT} state_t;

   function automatic int med_idx(input int n);
      return (n - 1) / 2;
   endfunction
endpackage

// File: rtl/sort_stats_acc.sv
// Per-burst accumulator: count, saturating sum, previous/min element, median and order check.
// start loads the first element of a burst; step folds in each further element in the same cycle.
module sort_stats_acc
   import sort_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int CNT_W = 8,
   parameter int SUM_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              step,
   input  logic [DATA_W-1:0] in_data,
   output logic [CNT_W-1:0]  count,
   output logic [SUM_W-1:0]  sum,
   output logic [DATA_W-1:0] prev,
   output logic [DATA_W-1:0] min_val,
   output logic [DATA_W-1:0] med,
   output logic              order_err
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] MED     = CNT_W'(med_idx(N));

   logic [SUM_W:0]   sum_ext;
   logic [SUM_W-1:0] sum_nxt;

   // Carry out of the widened add means the true sum no longer fits: clamp.
   always_comb begin
      sum_ext = {1'b0, sum} + (SUM_W + 1)'(in_data);
      sum_nxt = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         sum       <= '0;
         prev      <= '0;
         min_val   <= '0;
         med       <= '0;
         order_err <= 1'b0;
      end else if (start) begin
         count     <= CNT_W'(1);
         sum       <= SUM_W'(in_data);
         prev      <= in_data;
         min_val   <= in_data;
         order_err <= 1'b0;
         // Median cleared so a burst too short to reach it reports zero.
         med       <= (MED == '0) ? in_data : '0;
      end else if (step) begin
         count     <= (count == CNT_MAX) ? count : count + CNT_W'(1);
         sum       <= sum_nxt;
         order_err <= order_err | (in_data < prev);
         prev      <= in_data;
         if (count == MED)
            med <= in_data;
      end
   end
endmodule

// File: rtl/sort_stats_collector.sv
// Burst statistics collector: one result record per contiguous in_valid run, visible 1 cycle after
// the last element; record held until res_ready, a newer record overwrites it and flags res_overrun.
module sort_stats_collector
   import sort_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int CNT_W = 8,
   parameter int SUM_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              res_ready,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_min,
   output logic [DATA_W-1:0] res_max,
   output logic [DATA_W-1:0] res_med,
   output logic [SUM_W-1:0]  res_sum,
   output logic [CNT_W-1:0]  res_count,
   output logic              res_order_err,
   output logic              res_len_err,
   output logic              res_overrun
);
   state_t            state;
   logic              start;
   logic              step;
   logic              done;
   logic [CNT_W-1:0]  acc_count;
   logic [SUM_W-1:0]  acc_sum;
   logic [DATA_W-1:0] acc_prev;
   logic [DATA_W-1:0] acc_min;
   logic [DATA_W-1:0] acc_med;
   logic              acc_order_err;

   assign start = (state == IDLE) && in_valid;
   assign step  = (state == COLLECT) && in_valid;
   assign done  = (state == COLLECT) && !in_valid;

   sort_stats_acc #(.N(N), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_acc (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .step      (step),
      .in_data   (in_data),
      .count     (acc_count),
      .sum       (acc_sum),
      .prev      (acc_prev),
      .min_val   (acc_min),
      .med       (acc_med),
      .order_err (acc_order_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         res_valid     <= 1'b0;
         res_min       <= '0;
         res_max       <= '0;
         res_med       <= '0;
         res_sum       <= '0;
         res_count     <= '0;
         res_order_err <= 1'b0;
         res_len_err   <= 1'b0;
         res_overrun   <= 1'b0;
      end else begin
         case (state)
            IDLE:    state <= in_valid ? COLLECT : IDLE;
            COLLECT: state <= in_valid ? COLLECT : IDLE;
            default: state <= IDLE;
         endcase

         // A load wins over the accept of the same edge; the old record is lost if unaccepted.
         if (done) begin
            res_valid     <= 1'b1;
            res_min       <= acc_min;
            res_max       <= acc_prev;
            res_med       <= acc_med;
            res_sum       <= acc_sum;
            res_count     <= acc_count;
            res_order_err <= acc_order_err;
            res_len_err   <= (acc_count != CNT_W'(N));
            res_overrun   <= res_valid && !res_ready;
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sort_stats_collector.sv
// Self-checking bench for sort_stats_collector: directed scenarios plus randomized bursts vs a queue model.
module tb_sort_stats_collector;
   localparam int N     = 10;
   localparam int CNT_W = 8;
   localparam int SUM_W = 16;
   localparam int MED   = (N - 1) / 2;

   typedef logic [7:0] bq_t[$];

   typedef struct packed {
      logic [7:0]  mn;
      logic [7:0]  mx;
      logic [7:0]  md;
      logic [15:0] sum;
      logic [7:0]  cnt;
      logic        oe;
      logic        le;
      logic        ov;
   } rec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [7:0]       in_data;
   logic             res_ready;
   logic             res_valid;
   logic [7:0]       res_min;
   logic [7:0]       res_max;
   logic [7:0]       res_med;
   logic [SUM_W-1:0] res_sum;
   logic [CNT_W-1:0] res_count;
   logic             res_order_err;
   logic             res_len_err;
   logic             res_overrun;

   int n_cmp = 0;
   int n_bad = 0;

   sort_stats_collector #(.N(N), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .res_ready     (res_ready),
      .res_valid     (res_valid),
      .res_min       (res_min),
      .res_max       (res_max),
      .res_med       (res_med),
      .res_sum       (res_sum),
      .res_count     (res_count),
      .res_order_err (res_order_err),
      .res_len_err   (res_len_err),
      .res_overrun   (res_overrun)
   );

   always #5 clk = ~clk;

   // Reference: statistics straight from the burst contents.
   function automatic rec_t model(input bq_t q, input logic ov);
      rec_t r;
      int   s;
      r = '0;
      s = 0;
      r.mn = q[0];
      r.mx = q[q.size()-1];
      for (int i = 0; i < q.size(); i++) begin
         s += int'(q[i]);
         if (i > 0 && q[i] < q[i-1]) r.oe = 1'b1;
      end
      r.sum = (s > 65535) ? 16'hFFFF : 16'(s);
      r.cnt = (q.size() > 255) ? 8'd255 : 8'(q.size());
      r.md  = (q.size() > MED) ? q[MED] : 8'd0;
      r.le  = (q.size() != N);
      r.ov  = ov;
      return r;
   endfunction

   function automatic rec_t dut_rec();
      rec_t r;
      r = '{res_min, res_max, res_med, res_sum, res_count, res_order_err, res_len_err, res_overrun};
      return r;
   endfunction

   function automatic string fmt(input rec_t r);
      return $sformatf("min=%0d max=%0d med=%0d sum=%0d cnt=%0d oe=%0b le=%0b ov=%0b",
                       r.mn, r.mx, r.md, r.sum, r.cnt, r.oe, r.le, r.ov);
   endfunction

   // Drives one burst on consecutive cycles, then drops in_valid (the end cycle).
   task automatic send_burst(input bq_t q);
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = q[i];
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic test_reset();
      rec_t got;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      res_ready = 1'b0;
      #1;
      got = dut_rec();
      n_cmp++;
      if (res_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_valid: got %b need 0", res_valid);
      end
      n_cmp++;
      if (got !== rec_t'(0)) begin
         n_bad++;
         $display("FAIL reset_outputs: got %s need all zero", fmt(got));
      end
      repeat (2) @(negedge clk);
      rst_n     = 1'b1;
      res_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ascending();
      bq_t  q;
      rec_t exp, got;
      for (int i = 1; i <= 10; i++) q.push_back(8'(i));
      exp = model(q, 1'b0);
      send_burst(q);
      @(negedge clk);
      got = dut_rec();
      n_cmp++;
      if (res_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL asc_valid: got %b need 1", res_valid);
      end
      n_cmp++;
      if (got !== exp || got.sum !== 16'd55) begin
         n_bad++;
         $display("FAIL asc_record: got %s need %s", fmt(got), fmt(exp));
      end
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL asc_drop: got %b need 0", res_valid);
      end
   endtask

   task automatic test_order_err();
      bq_t  q;
      rec_t exp, got;
      q = '{8'd3, 8'd7, 8'd5, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
      exp = model(q, 1'b0);
      send_burst(q);
      @(negedge clk);
      got = dut_rec();
      n_cmp++;
      if (got !== exp || got.sum !== 16'd78 || got.oe !== 1'b1) begin
         n_bad++;
         $display("FAIL order_record: got %s need %s", fmt(got), fmt(exp));
      end
   endtask

   task automatic test_short();
      bq_t  q;
      rec_t exp, got;
      q = '{8'd2, 8'd4, 8'd6, 8'd8};
      exp = model(q, 1'b0);
      send_burst(q);
      @(negedge clk);
      got = dut_rec();
      n_cmp++;
      if (got !== exp || got.md !== 8'd0 || got.le !== 1'b1) begin
         n_bad++;
         $display("FAIL short_record: got %s need %s", fmt(got), fmt(exp));
      end
      q = '{8'd77};
      exp = model(q, 1'b0);
      send_burst(q);
      @(negedge clk);
      got = dut_rec();
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL single_record: got %s need %s", fmt(got), fmt(exp));
      end
   endtask

   task automatic test_back_to_back();
      bq_t  a, b, c;
      rec_t exp, got;
      for (int i = 0; i < N; i++) begin
         a.push_back(8'(i * 3));
         b.push_back(8'(100 + i));
         c.push_back(8'(200 + i));
      end
      @(negedge clk);
      res_ready = 1'b0;
      send_burst(a);
      send_burst(b);
      @(negedge clk);
      exp = model(b, 1'b1);
      got = dut_rec();
      n_cmp++;
      if (res_valid !== 1'b1 || got !== exp) begin
         n_bad++;
         $display("FAIL overrun_record: got v=%b %s need v=1 %s", res_valid, fmt(got), fmt(exp));
      end
      res_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL overrun_accept: got %b need 0", res_valid);
      end
      send_burst(c);
      @(negedge clk);
      exp = model(c, 1'b0);
      got = dut_rec();
      n_cmp++;
      if (res_valid !== 1'b1 || got !== exp) begin
         n_bad++;
         $display("FAIL after_overrun_record: got v=%b %s need v=1 %s", res_valid, fmt(got), fmt(exp));
      end
   endtask

   task automatic test_saturate();
      bq_t  q;
      rec_t exp, got;
      for (int i = 0; i < 300; i++) q.push_back(8'hFF);
      exp = model(q, 1'b0);
      send_burst(q);
      @(negedge clk);
      got = dut_rec();
      n_cmp++;
      if (got !== exp || got.cnt !== 8'd255 || got.sum !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL saturate_record: got %s need %s", fmt(got), fmt(exp));
      end
   endtask

   task automatic test_reset_mid_burst();
      bq_t  q;
      rec_t exp, got;
      // Leave a record pending so the async clear is observable.
      res_ready = 1'b0;
      send_burst('{8'd1, 8'd2, 8'd3});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'(10 + i);
      end
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      got = dut_rec();
      n_cmp++;
      if (res_valid !== 1'b0 || got !== rec_t'(0)) begin
         n_bad++;
         $display("FAIL midreset_async: got v=%b %s need all zero", res_valid, fmt(got));
      end
      @(negedge clk);
      rst_n     = 1'b1;
      res_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_no_record: got %b need 0", res_valid);
      end
      for (int i = 0; i < N; i++) q.push_back(8'(20 + i));
      exp = model(q, 1'b0);
      send_burst(q);
      @(negedge clk);
      got = dut_rec();
      n_cmp++;
      if (res_valid !== 1'b1 || got !== exp) begin
         n_bad++;
         $display("FAIL midreset_clean: got v=%b %s need v=1 %s", res_valid, fmt(got), fmt(exp));
      end
   endtask

   task automatic test_random();
      bq_t  q;
      rec_t exp, got;
      logic pending;
      logic rdy;
      int   len;
      pending = 1'b1;
      for (int it = 0; it < 25; it++) begin
         q.delete();
         len = $urandom_range(1, 14);
         for (int i = 0; i < len; i++) q.push_back(8'($urandom));
         if ($urandom_range(0, 3) != 0) q.sort();
         rdy = 1'($urandom_range(0, 1));
         // ready is held for the whole burst, so an older record is drained before the load iff rdy.
         exp = model(q, pending && !rdy);
         res_ready = rdy;
         send_burst(q);
         @(negedge clk);
         got = dut_rec();
         pending = 1'b1;
         n_cmp++;
         if (res_valid !== 1'b1 || got !== exp) begin
            n_bad++;
            $display("FAIL random_%0d: got v=%b %s need v=1 %s", it, res_valid, fmt(got), fmt(exp));
         end
      end
      res_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_ascending();
      test_order_err();
      test_short();
      test_back_to_back();
      test_saturate();
      test_reset_mid_burst();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
